// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush scheduler: load-use and taken-branch hazards plus a MULT/DIV
// occupancy sequencer, with a saturating count of PC-hold cycles.
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_id,
  input  logic [4:0]        rt_id,
  input  logic [4:0]        rt_ex,
  input  logic              ex_mem_read,
  input  logic              branch_taken,
  input  logic              mdu_start,
  input  logic              mdu_is_div,
  output logic              hold_pc,
  output logic              hold_if,
  output logic              bubble_id,
  output logic              flush_if,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [PERF_W-1:0] stall_cycles
);

  // state    | meaning
  // RUN      | normal issue; load-use stall or branch flush decided in-cycle
  // MDU_WAIT | MULT/DIV occupies EX; front end held, ID bubbled
  // MDU_DONE | one-cycle HI/LO writeback pulse; otherwise behaves as RUN
  // ILLEGAL  | unreachable encoding; outputs quiet, returns to RUN
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MDU_DONE = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic               lu;
  logic               hold;

  assign lu = ex_mem_read && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold     = 1'b0;
    flush_if = 1'b0;
    mdu_busy = 1'b0;
    mdu_done = 1'b0;
    case (state_q)
      RUN, MDU_DONE: begin
        mdu_done = (state_q == MDU_DONE);
        state_d  = RUN;
        // An issuing MULT/DIV wins over hazards; the ID instruction is re-seen later.
        if (mdu_start) begin
          cnt_d   = mdu_is_div ? DIV_LOAD : MULT_LOAD;
          state_d = MDU_WAIT;
        end else if (lu) begin
          hold = 1'b1;
        end else if (branch_taken) begin
          flush_if = 1'b1;
        end
      end
      MDU_WAIT: begin
        hold     = 1'b1;
        mdu_busy = 1'b1;
        if (cnt_q == '0) state_d = MDU_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    stall_cycles_d = stall_cycles_q;
    if (hold && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + PERF_W'(1);
  end

  assign hold_pc      = hold;
  assign hold_if      = hold;
  assign bubble_id    = hold;
  assign stall_cycles = stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline; drives PC hold, IF/ID hold, ID bubble-select and IF/ID flush.
- Arbitrates three stall sources: load-use hazards (ID vs EX), taken branches resolved in ID, and multi-cycle MULT/DIV occupancy in EX.
- Replaces the purely combinational hazard detection in ID. Adds a sequencing FSM for the multiply/divide unit and a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 4, EX occupancy of a multiply in cycles (min 1)
- DIV_CYCLES, 32, EX occupancy of a divide in cycles (min 1)
- CNT_W, 6, width of the occupancy down-counter (must hold max(MULT_CYCLES,DIV_CYCLES)-1)
- PERF_W, 16, width of the stall performance counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- rs_id  in  5  rs field of instruction in ID
- rt_id  in  5  rt field of instruction in ID
- rt_ex  in  5  rt (dest) of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- branch_taken  in  1  ID branch resolved taken (equal & branch)
- mdu_start  in  1  MULT/DIV issued into EX this cycle
- mdu_is_div  in  1  qualifies mdu_start: 1=divide, 0=multiply
- hold_pc  out  1  freeze PC
- hold_if  out  1  freeze IF/ID register
- bubble_id  out  1  force ID control outputs to zero (NOP)
- flush_if  out  1  zero IF/ID register at next edge
- mdu_busy  out  1  MDU occupying EX
- mdu_done  out  1  one-cycle pulse enabling HI/LO writeback
- stall_cycles  out  PERF_W  saturating count of cycles with hold_pc=1

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=RUN, down-counter=0, stall_cycles=0. All 1-bit outputs 0 in the cycle after rst is sampled high. A reset mid-MDU_WAIT aborts the operation with no mdu_done pulse.
- lu (combinational) = ex_mem_read && rt_ex!=0 && (rt_ex==rs_id || rt_ex==rt_id).
- States: RUN(2'd0), MDU_WAIT(2'd1), MDU_DONE(2'd2). 2'd3 is illegal and recovers to RUN next cycle with all outputs 0.
- RUN / MDU_DONE, in priority order, evaluated in the current cycle:
  1. mdu_start=1: load counter with (mdu_is_div ? DIV_CYCLES : MULT_CYCLES)-1, next=MDU_WAIT. lu and branch are ignored this cycle; all holds 0.
  2. else lu=1: hold_pc=hold_if=bubble_id=1 (same-cycle, Mealy). flush_if=0 even if branch_taken=1; the branch is re-evaluated next cycle. Stay/next=RUN.
  3. else branch_taken=1: flush_if=1, holds 0, next=RUN.
  4. else all 0, next=RUN.
- MDU_DONE additionally asserts mdu_done=1 for exactly its one cycle. mdu_busy=0 in MDU_DONE.
- MDU_WAIT:
  - hold_pc=hold_if=bubble_id=1, mdu_busy=1, flush_if=0.
  - mdu_start, branch_taken and lu are ignored.
  - Counter decrements each cycle. When the counter==0 in this cycle, next=MDU_DONE.
- Timing: mdu_start in cycle T gives holds in cycles T+1..T+N (N = selected cycles) and mdu_done in T+N+1. Back-to-back: mdu_start in MDU_DONE re-enters MDU_WAIT at T+N+2.
- stall_cycles: increments by 1 at each edge where hold_pc=1. It saturates at all-ones and does not wrap.

Test Plan:
- Reset: assert rst 2 cycles during MDU_WAIT -> state=RUN, all outputs 0, stall_cycles=0, no mdu_done pulse.
- Load-use: ex_mem_read=1, rt_ex=5, rs_id=5 -> hold_pc=hold_if=bubble_id=1 same cycle. Same stimulus with rt_ex=0 -> all 0. Same stimulus with rt_id=5, rs_id=3 -> stall.
- Branch: branch_taken=1, no lu -> flush_if=1 one cycle, holds 0. branch_taken=1 together with lu (rt_ex=7=rt_id) -> flush_if=0, stall=1.
- Multiply: mdu_start=1, mdu_is_div=0 at T -> mdu_busy and holds 1 for T+1..T+4, mdu_done=1 at T+5 only. stall_cycles goes 0->4.
- Divide back-to-back: div at T, second mdu_start in MDU_DONE (T+33) -> holds T+1..T+32, mdu_done T+33, holds T+34..T+65, mdu_done T+66.
- Saturation: PERF_W=4, stall 20 cycles -> stall_cycles=15, held at 15.
